// File: rtl/rc4_pkg.sv
// ============================================================================
//  Module   : rc4_pkg
//  Brief    : Shared types and constants for the RC4 init / KSA / PRGA stages.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package rc4_pkg;

    localparam int S_SIZE      = 256;
    localparam int DEF_MSG_LEN = 32;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ADDR_I = 4'd1,
        CAP_I  = 4'd2,
        ADDR_J = 4'd3,
        CAP_J  = 4'd4,
        WR_I   = 4'd5,
        WR_J   = 4'd6,
        ADDR_F = 4'd7,
        CAP_F  = 4'd8,
        WR_OUT = 4'd9,
        DONE   = 4'd10
    } prga_state_t;

endpackage

`default_nettype wire

// File: rtl/rc4_prga.sv
// ============================================================================
//  Module   : rc4_prga
//  Brief    : RC4 keystream generation over the shared S RAM, XOR-decrypting
//             the encrypted ROM into the decrypted-message RAM (9 cycles/byte).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rc4_prga
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = DEF_MSG_LEN,
    parameter int K_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [7:0]     s_addr,
    output logic [7:0]     s_wdata,
    output logic           s_wren,
    input  logic [7:0]     s_rdata,
    output logic [K_W-1:0] rom_addr,
    input  logic [7:0]     rom_q,
    output logic [K_W-1:0] dec_addr,
    output logic [7:0]     dec_wdata,
    output logic           dec_wren
);

    localparam logic [K_W-1:0] K_LAST = K_W'((MSG_LEN - 1) % S_SIZE);

    prga_state_t    r_state;
    prga_state_t    w_next;

    byte_t          r_i;
    byte_t          r_j;
    byte_t          r_si;
    byte_t          r_sj;
    byte_t          r_f;
    byte_t          r_enc;
    logic [K_W-1:0] r_k;
    byte_t          w_f_addr;
    logic           w_last;

    assign w_f_addr = r_si + r_sj;
    assign w_last   = (r_k == K_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        s_addr    = 8'd0;
        s_wdata   = 8'd0;
        s_wren    = 1'b0;
        rom_addr  = '0;
        dec_addr  = '0;
        dec_wdata = 8'd0;
        dec_wren  = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = ADDR_I;
            end
            ADDR_I: begin
                s_addr   = r_i;
                rom_addr = r_k;
                w_next   = CAP_I;
            end
            CAP_I:  w_next = ADDR_J;
            ADDR_J: begin
                s_addr = r_j;
                w_next = CAP_J;
            end
            CAP_J:  w_next = WR_I;
            // When i == j both writes target one address with one value.
            WR_I: begin
                s_addr  = r_i;
                s_wdata = r_sj;
                s_wren  = 1'b1;
                w_next  = WR_J;
            end
            WR_J: begin
                s_addr  = r_j;
                s_wdata = r_si;
                s_wren  = 1'b1;
                w_next  = ADDR_F;
            end
            ADDR_F: begin
                s_addr = w_f_addr;
                w_next = CAP_F;
            end
            CAP_F:  w_next = WR_OUT;
            WR_OUT: begin
                dec_addr  = r_k;
                dec_wdata = r_f ^ r_enc;
                dec_wren  = 1'b1;
                w_next    = w_last ? DONE : ADDR_I;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) w_next = ADDR_I;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i   <= 8'd0;
            r_j   <= 8'd0;
            r_k   <= '0;
            r_si  <= 8'd0;
            r_sj  <= 8'd0;
            r_f   <= 8'd0;
            r_enc <= 8'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_i <= 8'd1;
                        r_j <= 8'd0;
                        r_k <= '0;
                    end
                end
                CAP_I: begin
                    r_si  <= s_rdata;
                    r_enc <= rom_q;
                    r_j   <= r_j + s_rdata;
                end
                CAP_J:  r_sj <= s_rdata;
                CAP_F:  r_f  <= s_rdata;
                WR_OUT: begin
                    if (!w_last) begin
                        r_k <= r_k + K_W'(1);
                        r_i <= r_i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/rc4_prga.md
# rc4_prga

RC4 pseudo-random generation and decrypt stage, directly downstream of the KSA shuffle. After the KSA has left a fully permuted S array in `s_memory`, this block continues the RC4 keystream algorithm over that same S RAM. It XORs each keystream byte with the matching byte of the encrypted-message ROM and writes the plaintext into the decrypted-message RAM. A top-level controller starts it with `start` and watches `done`.

## Interface
Parameters:
- `MSG_LEN`, default 32: number of message bytes processed; legal range 1..256.
- `K_W`, default `$clog2(MSG_LEN)` (min 1): width of message address/counter.

Ports:
- `clk`  in  1  system clock (`CLOCK_50` at top)
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE or DONE
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is entered
- `done`  out  1  high while in DONE
- `s_addr`  out  8  S RAM address
- `s_wdata`  out  8  S RAM write data
- `s_wren`  out  1  S RAM write enable
- `s_rdata`  in  8  S RAM q; valid one cycle after address is presented
- `rom_addr`  out  K_W  encrypted ROM address
- `rom_q`  in  8  encrypted ROM data; 1-cycle latency
- `dec_addr`  out  K_W  decrypted RAM address
- `dec_wdata`  out  8  decrypted RAM write data
- `dec_wren`  out  1  decrypted RAM write enable

## Operation
- All arithmetic on `i`, `j` and `si+sj` is 8-bit, modulo 256. `k` runs 0..MSG_LEN-1.
- On `start` in IDLE or DONE: `i<=1`, `j<=0`, `k<=0`, go to ADDR_I.
- Per-byte sequence, one state per cycle, 9 cycles per byte:
  - ADDR_I: `s_addr=i`, `rom_addr=k`.
  - CAP_I: `si<=s_rdata`, `enc<=rom_q`, `j<=j+s_rdata`.
  - ADDR_J: `s_addr=j`.
  - CAP_J: `sj<=s_rdata`.
  - WR_I: `s_addr=i`, `s_wdata=sj`, `s_wren=1`.
  - WR_J: `s_addr=j`, `s_wdata=si`, `s_wren=1`.
  - ADDR_F: `s_addr=si+sj`.
  - CAP_F: `f<=s_rdata`.
  - WR_OUT: `dec_addr=k`, `dec_wdata=f^enc`, `dec_wren=1`.
- Leaving WR_OUT:
  - if `k==MSG_LEN-1` go to DONE;
  - else `k<=k+1`, `i<=i+1`, go to ADDR_I.
- DONE holds `done=1` until the next `start`, which restarts from the current S contents.
- `start` while busy is ignored.
- When `i==j`, both writes hit the same address with the same value; S is unchanged and this is required.
- When `MSG_LEN=256`, `i` wraps 255→0 on the last byte; no special handling.
- Outside the write states, `s_wren` and `dec_wren` are 0.
- In IDLE and DONE, all address and data outputs are 0, so the top-level S-RAM mux may OR or select freely.

## Timing
- Reset (asynchronous, active-low):
  - state IDLE; `i`, `j`, `k`, `si`, `sj`, `f`, `enc` all 0;
  - `busy=0`, `done=0`, all memory outputs 0.
- Reset mid-run aborts immediately. S and decrypted RAM are left partially written, and the controller must rerun init + KSA.
- `start` sampled high at edge 0 puts ADDR_I in cycle 1; `busy` rises in cycle 1.
- First `dec_wren` occurs in cycle 9; byte n is written in cycle 9(n+1).
- `done` rises in cycle 9·MSG_LEN+1, and `busy` falls in the same cycle.
- S RAM read-after-write: the WR_J write lands before the ADDR_F read is issued, so no bypass is needed.

## Structure
- `rc4_pkg` holds:
  - state enum `prga_state_t` (IDLE, ADDR_I, CAP_I, ADDR_J, CAP_J, WR_I, WR_J, ADDR_F, CAP_F, WR_OUT, DONE);
  - `typedef logic [7:0] byte_t`;
  - constant `S_SIZE=256`;
  - default `MSG_LEN=32`.
- The package is shared with the KSA and init stages.
- Single module; no sub-module is natural. Use one state register and a registered datapath, with outputs decoded from the state.

## Test plan
- Identity S (`s[x]=x`) and ROM all 0x00, MSG_LEN=3 → dec = 0x02, 0x05, 0x07; after the run, S[2]=3, S[3]=5, S[5]=2.
- S preloaded from the reference-model KSA of key 0x4B6579, ROM = BB F3 16 E8 D9 40 AF 0A D3, MSG_LEN=9 → dec spells "Plaintext"; `done` rises at cycle 82.
- Identity S, MSG_LEN=256 → `i` wraps to 0 on byte 255, no X on any address, and the final S is a permutation (checksum 0x7F80 = sum 0..255).
- `start` pulsed again at cycle 20 → ignored: the sequence, `done` timing and output bytes are identical to a single start.
- Assert `reset_n=0` at cycle 30 → the same cycle shows `busy=0`, `s_wren=0`, `dec_wren=0`; a new `start` after release runs cleanly from `i=1`, `j=0`.
- `start` held high in DONE → the run restarts on the next edge; `done` drops in the following cycle.
